// File: rtl/clock_pkg.sv
// clock_pkg: alarm ring FSM state encoding and default ring/snooze durations.
package clock_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2,
        ST_LOCK   = 2'd3
    } state_t;
    localparam int RING_SEC   = 60;
    localparam int SNOOZE_SEC = 300;
endpackage

// File: rtl/alarm_ring_ctrl_sec_timer.sv
// sec_timer: clearable second counter with tick enable and terminal-count compare.
module sec_timer #(
    parameter int CNT_W = 9
) (
    input  logic             CP,
    input  logic             CR,
    input  logic             clr,
    input  logic             tick,
    input  logic [CNT_W-1:0] term,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_nxt,
    output logic             done
);
    assign cnt_nxt = clr ? '0 : tick ? cnt + 1'b1 : cnt;
    assign done    = tick & (cnt == term);
    always_ff @(posedge CP or posedge CR)
        if (CR) cnt <= '0;
        else    cnt <= cnt_nxt;
endmodule

// File: rtl/alarm_ring_ctrl.sv
// alarm_ring_ctrl: ring/snooze/stop/timeout sequencer driven by the alarm match level.
module alarm_ring_ctrl
    import clock_pkg::*;
#(
    parameter int RING_SEC   = clock_pkg::RING_SEC,
    parameter int SNOOZE_SEC = clock_pkg::SNOOZE_SEC,
    parameter int MAX_SNOOZE = 3,
    parameter int CNT_W      = 9
) (
    input  logic       CP,
    input  logic       CR,
    input  logic       tick_1hz,
    input  logic       alarm_en,
    input  logic       alarm_hit,
    input  logic       snooze_btn,
    input  logic       stop_btn,
    output logic       ring,
    output logic       light,
    output logic [1:0] state,
    output logic [1:0] snooze_cnt
);
    state_t           cur, nxt;
    logic             hit_q, hit_rise, clr, done, snz_ok, timing;
    logic [1:0]       sc_nxt;
    logic [CNT_W-1:0] sec_cnt, sec_nxt, term;

    assign hit_rise = alarm_hit & ~hit_q;
    assign snz_ok   = snooze_cnt < 2'(MAX_SNOOZE);
    assign timing   = (cur == ST_RING) || (cur == ST_SNOOZE);
    assign term     = (cur == ST_RING) ? CNT_W'(RING_SEC - 1) : CNT_W'(SNOOZE_SEC - 1);
    // Every state change restarts the second count, so it never wraps.
    assign clr      = nxt != cur;
    assign state    = cur;

    sec_timer #(.CNT_W(CNT_W)) u_timer (
        .CP     (CP),
        .CR     (CR),
        .clr    (clr),
        .tick   (tick_1hz & timing),
        .term   (term),
        .cnt    (sec_cnt),
        .cnt_nxt(sec_nxt),
        .done   (done)
    );

    always_comb begin
        nxt    = cur;
        sc_nxt = snooze_cnt;
        case (cur)
            ST_IDLE: if (hit_rise && alarm_en) begin
                nxt    = ST_RING;
                sc_nxt = '0;
            end
            ST_RING: if (!alarm_en || stop_btn) nxt = ST_LOCK;
            else if (snooze_btn) begin
                nxt    = snz_ok ? ST_SNOOZE : ST_LOCK;
                sc_nxt = snz_ok ? snooze_cnt + 2'd1 : snooze_cnt;
            end
            else if (done) nxt = ST_LOCK;
            ST_SNOOZE: if (!alarm_en || stop_btn) nxt = ST_LOCK;
            else if (done) nxt = ST_RING;
            default: if (!alarm_hit) nxt = ST_IDLE;
        endcase
    end

    // ring/light are computed from next-state values so they stay registered yet in step with state.
    always_ff @(posedge CP or posedge CR)
        if (CR) begin
            cur        <= ST_IDLE;
            hit_q      <= 1'b0;
            snooze_cnt <= '0;
            ring       <= 1'b0;
            light      <= 1'b0;
        end else begin
            cur        <= nxt;
            hit_q      <= alarm_hit;
            snooze_cnt <= sc_nxt;
            ring       <= nxt == ST_RING;
            light      <= (nxt == ST_RING) & ~sec_nxt[0];
        end
endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// tb_alarm_ring_ctrl: scoreboard bench for the alarm ring sequencer.
module tb_alarm_ring_ctrl;
    import clock_pkg::*;

    logic       CP = 1'b0, CR = 1'b1;
    logic       tick_1hz = 1'b0, alarm_en = 1'b0, alarm_hit = 1'b0;
    logic       snooze_btn = 1'b0, stop_btn = 1'b0;
    logic       ring, light;
    logic [1:0] state, snooze_cnt;
    logic       hit = 1'b0, en = 1'b1;

    typedef struct {
        int    cyc;
        string tag;
        int    ring;
        int    light;
        int    st;
        int    sc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   ncyc = 0, n_cmp = 0, n_err = 0;

    always #5 CP = ~CP;

    alarm_ring_ctrl dut (
        .CP        (CP),
        .CR        (CR),
        .tick_1hz  (tick_1hz),
        .alarm_en  (alarm_en),
        .alarm_hit (alarm_hit),
        .snooze_btn(snooze_btn),
        .stop_btn  (stop_btn),
        .ring      (ring),
        .light     (light),
        .state     (state),
        .snooze_cnt(snooze_cnt)
    );

    task automatic chk(input string tag, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic cyc(input logic t, input logic s, input logic p);
        @(negedge CP);
        tick_1hz   = t;
        snooze_btn = s;
        stop_btn   = p;
        alarm_hit  = hit;
        alarm_en   = en;
    endtask

    task automatic push(input string tag, input int r, input int l, input int st, input int sc);
        sb.push_back('{ncyc + 1, tag, r, l, st, sc});
    endtask

    task automatic sec(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
        end
    endtask

    always @(posedge CP) begin
        ncyc++;
        #1;
        while (sb.size() > 0 && sb[0].cyc <= ncyc) begin
            e = sb.pop_front();
            chk({e.tag, ".ring"},  int'(ring),       e.ring);
            chk({e.tag, ".light"}, int'(light),      e.light);
            chk({e.tag, ".state"}, int'(state),      e.st);
            chk({e.tag, ".snz"},   int'(snooze_cnt), e.sc);
        end
    end

    initial begin
        repeat (2) @(posedge CP);
        #2;
        chk("rst.ring", int'(ring), 0);
        chk("rst.light", int'(light), 0);
        chk("rst.state", int'(state), 0);
        chk("rst.snz", int'(snooze_cnt), 0);
        @(negedge CP);
        CR = 1'b0;
        cyc(0, 0, 0); push("idle", 0, 0, 0, 0);

        // ring, light blink, auto-timeout
        hit = 1; cyc(0, 0, 0); push("ring_rise", 1, 1, 1, 0);
        cyc(1, 0, 0); push("light_odd", 1, 0, 1, 0);
        hit = 0; cyc(0, 0, 0); push("light_hold", 1, 0, 1, 0);
        cyc(1, 0, 0); push("light_even", 1, 1, 1, 0);
        cyc(0, 0, 0);
        sec(56);
        cyc(1, 0, 0); push("pre_timeout", 1, 0, 1, 0);
        cyc(0, 0, 0);
        cyc(1, 0, 0); push("timeout", 0, 0, 3, 0);
        cyc(0, 0, 0); push("lock_exit", 0, 0, 0, 0);

        // snooze at tick 10, re-ring after 300 ticks
        hit = 1; cyc(0, 0, 0); push("ring2", 1, 1, 1, 0);
        hit = 0; sec(10);
        cyc(0, 1, 0); push("snooze1", 0, 0, 2, 1);
        sec(298);
        cyc(1, 0, 0); push("pre_rering", 0, 0, 2, 1);
        cyc(0, 0, 0);
        cyc(1, 0, 0); push("rering", 1, 1, 1, 1);

        // snooze limit: presses 2, 3 accepted, 4th acts as stop
        cyc(0, 1, 0); push("snooze2", 0, 0, 2, 2);
        sec(300); push("rering2", 1, 1, 1, 2);
        cyc(0, 1, 0); push("snooze3", 0, 0, 2, 3);
        sec(300); push("rering3", 1, 1, 1, 3);
        cyc(0, 1, 0); push("snz_limit", 0, 0, 3, 3);
        cyc(0, 0, 0); push("idle_keep_snz", 0, 0, 0, 3);

        // stop and snooze together
        hit = 1; cyc(0, 0, 0); push("ring3", 1, 1, 1, 0);
        hit = 0; cyc(0, 1, 1); push("stop_snz", 0, 0, 3, 0);
        cyc(0, 0, 0); push("idle2", 0, 0, 0, 0);

        // lockout holds while alarm_hit stays high
        hit = 1; cyc(0, 0, 0); push("ring4", 1, 1, 1, 0);
        sec(5);
        cyc(0, 0, 1); push("stop", 0, 0, 3, 0);
        sec(3);
        cyc(0, 0, 0); push("lock_held", 0, 0, 3, 0);
        hit = 0; cyc(0, 0, 0); push("lock_release", 0, 0, 0, 0);
        hit = 1; cyc(0, 0, 0); push("retrigger", 1, 1, 1, 0);

        // alarm_en drop in SNOOZE overrides the tick
        cyc(0, 1, 0); push("snooze_en", 0, 0, 2, 1);
        en = 0; cyc(1, 0, 0); push("en_drop", 0, 0, 3, 1);
        hit = 0; cyc(0, 0, 0); push("idle3", 0, 0, 0, 1);
        hit = 1; cyc(0, 0, 0); push("disarmed", 0, 0, 0, 1);
        hit = 0; en = 1; cyc(0, 0, 0); push("idle4", 0, 0, 0, 1);

        // asynchronous reset mid-ring
        hit = 1; cyc(0, 0, 0); push("ring5", 1, 1, 1, 0);
        @(posedge CP);
        #3;
        CR = 1'b1;
        alarm_hit = 1'b0;
        hit = 0;
        #1;
        chk("async_rst.ring", int'(ring), 0);
        chk("async_rst.light", int'(light), 0);
        chk("async_rst.state", int'(state), 0);
        @(negedge CP);
        CR = 1'b0;
        cyc(0, 0, 0); push("post_rst", 0, 0, 0, 0);

        repeat (2) @(posedge CP);
        #2;
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
